multi_key_debouncer: RTL and testbench

- Parametrised, multi-channel successor to the single-key debouncer. It handles NUM_KEYS asynchronous key/pin inputs, each with its own synchroniser, glitch filter and per-key state machine.
- Outputs per key: the debounced level, a press strobe, a release strobe, and an optional long-press strobe.
- Sits between board-level buttons/switches and control logic clocked by clk_i.

---
 rtl/debouncer_pkg.sv | 34 +++
 rtl/debounce_channel.sv | 129 ++++++++++++
 rtl/multi_key_debouncer.sv | 37 +++
 tb/tb_multi_key_debouncer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/debouncer_pkg.sv
// Shared types and elaboration-time helpers for the multi-key debouncer.
package debouncer_pkg;

  typedef enum logic [1:0] {
    KEY_RELEASED = 2'd0,
    KEY_PRESSED  = 2'd1,
    KEY_HELD     = 2'd2
  } key_fsm_t;

  // Rounds up so that a non-integral cycle count never shortens the required time.
  function automatic longint unsigned calc_cycles(input longint unsigned time_val,
                                                  input longint unsigned freq_mhz,
                                                  input longint unsigned div);
    if (div == 64'd0) begin
      return 64'd0;
    end else begin
      return (time_val * freq_mhz + div - 64'd1) / div;
    end
  endfunction

  function automatic int clog2_min1(input longint unsigned value);
    int res;
    res = 0;
    for (int i = 0; i < 63; i++) begin
      if ((64'd1 << i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return (res < 1) ? 1 : res;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One key channel: 3-flop synchroniser, glitch filter, long-press counter and FSM.
module debounce_channel
  import debouncer_pkg::*;
#(
  parameter int unsigned GLITCH_TIME_NS = 10000,
  parameter int unsigned CLK_FREQ_MHZ   = 150,
  parameter int unsigned ACTIVE_LOW     = 0,
  parameter int unsigned LONG_PRESS_US  = 500000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic key_i,
  output logic key_state_o,
  output logic key_pressed_stb_o,
  output logic key_released_stb_o,
  output logic key_long_stb_o
);

  localparam longint unsigned G_RAW = calc_cycles(64'(GLITCH_TIME_NS), 64'(CLK_FREQ_MHZ), 64'd1000);
  localparam longint unsigned G     = (G_RAW < 64'd1) ? 64'd1 : G_RAW;
  localparam longint unsigned L     = calc_cycles(64'(LONG_PRESS_US), 64'(CLK_FREQ_MHZ), 64'd1);
  localparam int DB_CNT_W = clog2_min1(G + 64'd1);
  localparam int LP_CNT_W = clog2_min1(L + 64'd1);
  localparam logic [DB_CNT_W-1:0] G_LAST = DB_CNT_W'(G - 64'd1);
  localparam logic [LP_CNT_W-1:0] L_LAST = (L > 64'd0) ? LP_CNT_W'(L - 64'd1) : {LP_CNT_W{1'b0}};
  localparam logic [LP_CNT_W-1:0] LP_MAX = {LP_CNT_W{1'b1}};
  localparam logic IDLE_LVL = (ACTIVE_LOW != 0);
  localparam bit   LONG_EN  = (L > 64'd0);

  logic [2:0]          key_d_r;
  logic [DB_CNT_W-1:0] db_cnt_r, db_cnt_nxt_s;
  logic [LP_CNT_W-1:0] lp_cnt_r, lp_cnt_nxt_s;
  key_fsm_t            fsm_r, fsm_nxt_s;
  logic state_nxt_s, press_nxt_s, release_nxt_s, long_nxt_s;
  logic sample_s, accept_s, press_acc_s, release_acc_s;

  assign sample_s      = key_d_r[2] ^ IDLE_LVL;
  assign accept_s      = (sample_s != key_state_o) && (db_cnt_r == G_LAST);
  assign press_acc_s   = accept_s & sample_s;
  assign release_acc_s = accept_s & ~sample_s;

  // Synchroniser resets to the idle raw level so reset cannot look like a press.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      key_d_r <= {3{IDLE_LVL}};
    end else begin
      key_d_r <= {key_d_r[1:0], key_i};
    end
  end

  // Next-state logic for the glitch filter, long counter and key FSM.
  always_comb begin
    db_cnt_nxt_s  = db_cnt_r;
    lp_cnt_nxt_s  = lp_cnt_r;
    fsm_nxt_s     = fsm_r;
    state_nxt_s   = key_state_o;
    press_nxt_s   = 1'b0;
    release_nxt_s = 1'b0;
    long_nxt_s    = 1'b0;
    if (sample_s == key_state_o) begin
      db_cnt_nxt_s = {DB_CNT_W{1'b0}};
    end else if (db_cnt_r == G_LAST) begin
      state_nxt_s  = sample_s;
      db_cnt_nxt_s = {DB_CNT_W{1'b0}};
    end else begin
      db_cnt_nxt_s = db_cnt_r + {{(DB_CNT_W-1){1'b0}}, 1'b1};
    end
    case (fsm_r)
      KEY_RELEASED: begin
        lp_cnt_nxt_s = {LP_CNT_W{1'b0}};
        if (press_acc_s) begin
          fsm_nxt_s   = KEY_PRESSED;
          press_nxt_s = 1'b1;
        end else begin
          fsm_nxt_s = KEY_RELEASED;
        end
      end
      KEY_PRESSED: begin
        if (release_acc_s) begin
          fsm_nxt_s     = KEY_RELEASED;
          release_nxt_s = 1'b1;
          lp_cnt_nxt_s  = {LP_CNT_W{1'b0}};
        end else if (LONG_EN && (lp_cnt_r == L_LAST)) begin
          fsm_nxt_s  = KEY_HELD;
          long_nxt_s = 1'b1;
        end else if (lp_cnt_r != LP_MAX) begin
          lp_cnt_nxt_s = lp_cnt_r + {{(LP_CNT_W-1){1'b0}}, 1'b1};
        end else begin
          lp_cnt_nxt_s = lp_cnt_r;
        end
      end
      KEY_HELD: begin
        if (release_acc_s) begin
          fsm_nxt_s     = KEY_RELEASED;
          release_nxt_s = 1'b1;
          lp_cnt_nxt_s  = {LP_CNT_W{1'b0}};
        end else begin
          fsm_nxt_s = KEY_HELD;
        end
      end
      default: begin
        fsm_nxt_s    = KEY_RELEASED;
        lp_cnt_nxt_s = {LP_CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and registered output update.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      db_cnt_r           <= {DB_CNT_W{1'b0}};
      lp_cnt_r           <= {LP_CNT_W{1'b0}};
      fsm_r              <= KEY_RELEASED;
      key_state_o        <= 1'b0;
      key_pressed_stb_o  <= 1'b0;
      key_released_stb_o <= 1'b0;
      key_long_stb_o     <= 1'b0;
    end else begin
      db_cnt_r           <= db_cnt_nxt_s;
      lp_cnt_r           <= lp_cnt_nxt_s;
      fsm_r              <= fsm_nxt_s;
      key_state_o        <= state_nxt_s;
      key_pressed_stb_o  <= press_nxt_s;
      key_released_stb_o <= release_nxt_s;
      key_long_stb_o     <= long_nxt_s;
    end
  end

endmodule

// File: rtl/multi_key_debouncer.sv
// NUM_KEYS independent debounce channels sharing one clock and reset.
module multi_key_debouncer
  import debouncer_pkg::*;
#(
  parameter int unsigned NUM_KEYS       = 4,
  parameter int unsigned GLITCH_TIME_NS = 10000,
  parameter int unsigned CLK_FREQ_MHZ   = 150,
  parameter int unsigned ACTIVE_LOW     = 0,
  parameter int unsigned LONG_PRESS_US  = 500000
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [NUM_KEYS-1:0] key_i,
  output logic [NUM_KEYS-1:0] key_state_o,
  output logic [NUM_KEYS-1:0] key_pressed_stb_o,
  output logic [NUM_KEYS-1:0] key_released_stb_o,
  output logic [NUM_KEYS-1:0] key_long_stb_o
);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
    debounce_channel #(
      .GLITCH_TIME_NS(GLITCH_TIME_NS),
      .CLK_FREQ_MHZ  (CLK_FREQ_MHZ),
      .ACTIVE_LOW    (ACTIVE_LOW),
      .LONG_PRESS_US (LONG_PRESS_US)
    ) u_ch (
      .clk_i             (clk_i),
      .rst_n_i           (rst_n_i),
      .key_i             (key_i[k]),
      .key_state_o       (key_state_o[k]),
      .key_pressed_stb_o (key_pressed_stb_o[k]),
      .key_released_stb_o(key_released_stb_o[k]),
      .key_long_stb_o    (key_long_stb_o[k])
    );
  end

endmodule

// File: tb/tb_multi_key_debouncer.sv
// Directed bench: G=4, L=100, two channels, plus an ACTIVE_LOW instance.
module tb_multi_key_debouncer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key;
  logic [1:0] key_al;
  logic [1:0] state, pressed, released, long_stb;
  logic [1:0] al_state, al_pressed, al_released, al_long;

  int n_assert = 0;
  int n_fail   = 0;
  int pcnt[2]    = '{0, 0};
  int rcnt[2]    = '{0, 0};
  int lcnt[2]    = '{0, 0};
  int al_pcnt[2] = '{0, 0};
  int base_p, base_r, base_l;

  always #5 clk = ~clk;

  multi_key_debouncer #(
    .NUM_KEYS(2), .GLITCH_TIME_NS(40), .CLK_FREQ_MHZ(100), .ACTIVE_LOW(0), .LONG_PRESS_US(1)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .key_i(key), .key_state_o(state),
    .key_pressed_stb_o(pressed), .key_released_stb_o(released), .key_long_stb_o(long_stb)
  );

  multi_key_debouncer #(
    .NUM_KEYS(2), .GLITCH_TIME_NS(40), .CLK_FREQ_MHZ(100), .ACTIVE_LOW(1), .LONG_PRESS_US(1)
  ) dut_al (
    .clk_i(clk), .rst_n_i(rst_n), .key_i(key_al), .key_state_o(al_state),
    .key_pressed_stb_o(al_pressed), .key_released_stb_o(al_released), .key_long_stb_o(al_long)
  );

  // Strobe event counters, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      pcnt[i]    <= pcnt[i] + int'(pressed[i]);
      rcnt[i]    <= rcnt[i] + int'(released[i]);
      lcnt[i]    <= lcnt[i] + int'(long_stb[i]);
      al_pcnt[i] <= al_pcnt[i] + int'(al_pressed[i]);
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    key    = 2'b00;
    key_al = 2'b11;
    #23;
    chk("reset_outputs", 32'({state, pressed, released, long_stb}), 32'd0);
    chk("reset_outputs_al", 32'({al_state, al_pressed, al_released, al_long}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(12);
    chk("al_idle_no_press", 32'(al_pcnt[0] + al_pcnt[1]), 32'd0);
    chk("al_idle_state", 32'(al_state), 32'd0);

    // Clean press on channel 0
    key = 2'b01;
    tick(6);
    chk("press_edge6_state", 32'(state), 32'd0);
    chk("press_edge6_stb", 32'(pressed), 32'd0);
    tick(1);
    chk("press_edge7_state", 32'(state), 32'd1);
    chk("press_edge7_stb", 32'(pressed), 32'd1);
    tick(1);
    chk("press_stb_one_cycle", 32'(pressed), 32'd0);
    key = 2'b00;
    tick(7);
    chk("release_edge7_stb", 32'(released), 32'd1);
    chk("release_edge7_state", 32'(state), 32'd0);
    tick(2);
    chk("ch1_quiet", 32'(pcnt[1] + rcnt[1]), 32'd0);

    // Glitch rejection: 3-cycle highs are never accepted
    base_p = pcnt[0];
    base_r = rcnt[0];
    for (int i = 0; i < 10; i++) begin
      key = 2'b01;
      tick(3);
      key = 2'b00;
      tick(5);
    end
    tick(4);
    chk("glitch_no_press", 32'(pcnt[0] - base_p), 32'd0);
    chk("glitch_no_release", 32'(rcnt[0] - base_r), 32'd0);
    chk("glitch_state", 32'(state), 32'd0);

    // 4-cycle pulse: exactly one press then one release
    key = 2'b01;
    tick(4);
    key = 2'b00;
    tick(3);
    chk("pulse4_press", 32'(pressed), 32'd1);
    tick(3);
    chk("pulse4_hold", 32'({state, released}), 32'({2'b01, 2'b00}));
    tick(1);
    chk("pulse4_release", 32'({state, released}), 32'({2'b00, 2'b01}));
    tick(3);
    chk("pulse4_counts", 32'({pcnt[0] - base_p, rcnt[0] - base_r}), 32'({32'd1, 32'd1}));

    // Long press: strobe 100 cycles after the press strobe, once
    base_l = lcnt[0];
    key = 2'b01;
    tick(7);
    chk("long_press_stb", 32'(pressed), 32'd1);
    tick(99);
    chk("long_edge99", 32'(long_stb), 32'd0);
    tick(1);
    chk("long_edge100", 32'(long_stb), 32'd1);
    tick(50);
    chk("long_once_held", 32'(lcnt[0] - base_l), 32'd1);
    key = 2'b00;
    tick(7);
    chk("long_release_stb", 32'({released, long_stb}), 32'({2'b01, 2'b00}));
    tick(5);
    chk("long_once_after_rel", 32'(lcnt[0] - base_l), 32'd1);

    // ACTIVE_LOW: drop to 0 is a press
    key_al = 2'b10;
    tick(6);
    chk("al_edge6", 32'(al_pressed), 32'd0);
    tick(1);
    chk("al_press_edge7", 32'({al_state, al_pressed}), 32'({2'b01, 2'b01}));
    key_al = 2'b11;
    tick(8);
    chk("al_released_state", 32'(al_state), 32'd0);

    // Reset while HELD with key still down
    key = 2'b01;
    tick(112);
    chk("held_before_reset", 32'(state), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({state, pressed, released, long_stb}), 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(6);
    chk("post_reset_edge6", 32'({state, pressed}), 32'd0);
    tick(1);
    chk("post_reset_edge7", 32'({state, pressed}), 32'({2'b01, 2'b01}));
    key = 2'b00;
    tick(9);

    // Simultaneous channels
    key = 2'b11;
    tick(7);
    chk("both_press", 32'(pressed), 32'd3);
    tick(1);
    key = 2'b01;
    tick(7);
    chk("only_ch1_release", 32'({state, released}), 32'({2'b01, 2'b10}));
    key = 2'b00;
    tick(8);
    chk("all_released", 32'(state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
